cntr8_sched: RTL and testbench
==============================

Name: cntr8_sched

Overview:
Control sequencer for the 8-bit up/down counter datapath: its output logic computes the count from a 3-bit state code and an 8-bit load value. The block shares that datapath between two requesters using a req/gnt/done handshake with round-robin arbitration. It drives the state code cycle by cycle, including the INC/INC2 and DEC/DEC2 alternation needed for back-to-back steps. It replaces direct state driving by the top level.

Parameters:
WIDTH, 8, width of load value / counter datapath
REP_W, 4, width of repeat field; INC/DEC execute rep+1 steps

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req0  input  1  requester 0 command request; hold with op0/arg0/rep0 stable until gnt0
op0  input  2  00 CLR, 01 LOAD, 10 INC, 11 DEC
arg0  input  WIDTH  load value (LOAD only)
rep0  input  REP_W  repeat count (INC/DEC only)
req1, op1, arg1, rep1  input  1/2/WIDTH/REP_W  same for requester 1
gnt0, gnt1  output  1  one-cycle grant pulse, registered
done0, done1  output  1  one-cycle completion pulse to the owner, registered
busy  output  1  high while a command is granted/executing
state  output  3  to datapath output logic: IDLE 000, LOAD 001, INC 010, INC2 011, DEC 100, DEC2 101
d_in  output  WIDTH  load value to datapath; latched arg of the current owner

Behaviour:
- Reset (async, immediate): state=000, d_in=0, gnt*/done*/busy=0. Round-robin pointer favours req0. Phase bit=0. Any in-flight command is discarded and no done is issued.
- Internal FSM: S_IDLE -> S_EXEC -> S_DONE -> S_IDLE.
- S_IDLE: at a clock edge with any req high, grant and latch op/arg/rep.
  - Single requester: it wins.
  - Both requesting: the requester not granted most recently wins; the pointer updates on every grant.
  - No req: stay in S_IDLE.
- Grant cycle = first exec cycle: gntX=1 and busy=1 for that cycle, and state shows the first exec code.
- Step count N: CLR=1, LOAD=1, INC/DEC=rep+1, so rep=0 gives 1 step and rep=15 gives 16 steps.
- CLR: state=000 for 1 cycle. LOAD: state=001 for 1 cycle, with d_in=arg latched at the grant edge.
- INC/DEC: one step per cycle.
  - Each step emits INC or INC2 (DEC or DEC2) selected by the phase bit, 0 giving the plain code.
  - The phase bit toggles after every INC/DEC step cycle and persists across commands.
  - Consecutive step codes therefore always differ, so the datapath re-evaluates each cycle.
- After the last exec cycle: go to S_DONE for 1 cycle. doneX=1, busy=0, state holds the last code.
- S_DONE -> S_IDLE unconditionally. The earliest next grant is at the edge ending the S_DONE cycle. Minimum gap between commands: 1 cycle.
- Outside exec cycles, state holds the last emitted code and is never forced to IDLE, since forcing IDLE would clear the count. d_in holds its last value.
- Arithmetic wrap-around is in the datapath (mod 2^WIDTH). The scheduler does no saturation.
- A requester holding req high through its done is eligible at the next S_IDLE edge, but still loses to the other requester if that one is pending.
- gnt and done are never both high in the same cycle. done goes only to the granted owner.
- op/arg/rep changes after grant are ignored.

Test Plan:
1. Reset, then req0 LOAD arg=0x10 -> gnt0 in C1 with state=001 and d_in=0x10; done0 in C2; datapath count=0x10.
2. Then req0 INC rep=2 -> state 010,011,010 (phase starts 0) in C1–C3; done0 in C4; count=0x13; busy high exactly C1–C3.
3. LOAD 0xFF, then INC rep=0 -> count 0x00 (wrap). Then DEC rep=0 -> state=100 or 101, differing from the prior INC code; count=0xFF.
4. req0 and req1 asserted together and held -> grants alternate gnt0,gnt1,gnt0, each separated by one exec+done span. A lone req1 after gnt1 is granted again.
5. Assert rst mid INC rep=15 at step 5 -> state=000 immediately, no done pulse. Next LOAD 0x22 completes normally.
6. CLR after count=0x5A -> state=000 one cycle, count=0x00. The following INC rep=0 gives count=0x01.

Source files
------------

// File: rtl/cntr8_sched.sv
// cntr8_sched: sequences the shared 8-bit up/down counter datapath for two
// requesters. It arbitrates round-robin, latches the winning command and
// drives the datapath state code and load value one cycle at a time.
module cntr8_sched #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] arg0,
  input  logic [REP_W-1:0] rep0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] arg1,
  input  logic [REP_W-1:0] rep1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] d_in
);

  // command opcodes
  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;

  // datapath state codes
  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_LOAD = 3'b001;
  localparam logic [2:0] ST_INC  = 3'b010;
  localparam logic [2:0] ST_INC2 = 3'b011;
  localparam logic [2:0] ST_DEC  = 3'b100;
  localparam logic [2:0] ST_DEC2 = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t             fsm_r;
  logic             owner_r;   // 1 when requester 1 owns the datapath
  logic             last_r;    // most recently granted requester
  logic             phase_r;   // INC/INC2, DEC/DEC2 alternation bit
  logic [1:0]       op_r;
  logic [REP_W-1:0] cnt_r;     // steps remaining after the current one

  logic             any_req_s;
  logic             pick1_s;
  logic [1:0]       sel_op_s;
  logic [WIDTH-1:0] sel_arg_s;
  logic [REP_W-1:0] sel_rep_s;

  // Datapath code for one step of a command; the phase bit picks the
  // alternate code so back-to-back steps never repeat a code.
  function automatic logic [2:0] step_code(input logic [1:0] op, input logic phase);
    logic [2:0] code;
    case (op)
      OP_CLR:  code = ST_IDLE;
      OP_LOAD: code = ST_LOAD;
      OP_INC:  code = phase ? ST_INC2 : ST_INC;
      OP_DEC:  code = phase ? ST_DEC2 : ST_DEC;
      default: code = ST_IDLE;
    endcase
    return code;
  endfunction

  // Round-robin choice: a lone requester wins, on contention the one not
  // granted most recently wins; then mux the winner's command fields.
  always_comb begin
    any_req_s = req0 | req1;
    pick1_s   = 1'b0;
    if (req0 && req1) begin
      pick1_s = ~last_r;
    end else if (req1) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
    if (pick1_s) begin
      sel_op_s  = op1;
      sel_arg_s = arg1;
      sel_rep_s = rep1;
    end else begin
      sel_op_s  = op0;
      sel_arg_s = arg0;
      sel_rep_s = rep0;
    end
  end

  // Sequencer FSM with all outputs registered; the grant edge already
  // presents the first exec code, and state/d_in hold outside exec cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r   <= S_IDLE;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
      phase_r <= 1'b0;
      op_r    <= OP_CLR;
      cnt_r   <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
      state   <= ST_IDLE;
      d_in    <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (fsm_r)
        S_IDLE, S_DONE: begin
          if (any_req_s) begin
            fsm_r   <= S_EXEC;
            busy    <= 1'b1;
            owner_r <= pick1_s;
            last_r  <= pick1_s;
            op_r    <= sel_op_s;
            gnt0    <= ~pick1_s;
            gnt1    <= pick1_s;
            state   <= step_code(sel_op_s, phase_r);
            if (sel_op_s[1]) begin
              cnt_r   <= sel_rep_s;
              phase_r <= ~phase_r;
            end else begin
              cnt_r   <= '0;
            end
            if (sel_op_s == OP_LOAD) begin
              d_in <= sel_arg_s;
            end
          end else begin
            fsm_r <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (cnt_r == '0) begin
            fsm_r <= S_DONE;
            busy  <= 1'b0;
            done0 <= ~owner_r;
            done1 <= owner_r;
          end else begin
            cnt_r   <= cnt_r - {{(REP_W-1){1'b0}}, 1'b1};
            state   <= step_code(op_r, phase_r);
            phase_r <= ~phase_r;
          end
        end
        default: begin
          fsm_r <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cntr8_sched.sv
// Directed self-checking bench for cntr8_sched with a small counter model
// standing in for the datapath.
module tb_cntr8_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic [7:0] arg0 = 8'h00, arg1 = 8'h00;
  logic [3:0] rep0 = 4'h0, rep1 = 4'h0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [2:0] state;
  logic [7:0] d_in;

  logic [7:0] count_m;
  int         n_checks = 0;
  int         n_err = 0;
  logic [2:0] code;
  int         nb;
  int         seen;

  cntr8_sched #(.WIDTH(8), .REP_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .arg0(arg0), .rep0(rep0),
    .req1(req1), .op1(op1), .arg1(arg1), .rep1(rep1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .state(state), .d_in(d_in)
  );

  always #5 clk = ~clk;

  // datapath model: applies the presented code on every exec cycle
  always @(posedge clk or posedge rst) begin
    if (rst) count_m <= 8'h00;
    else if (busy) begin
      case (state)
        3'b000:         count_m <= 8'h00;
        3'b001:         count_m <= d_in;
        3'b010, 3'b011: count_m <= count_m + 8'h01;
        3'b100, 3'b101: count_m <= count_m - 8'h01;
        default:        count_m <= count_m;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // issue one command, wait (bounded) for grant and done, report first code
  task automatic do_cmd(input int who, input logic [1:0] op, input logic [7:0] arg,
                        input logic [3:0] rep, output logic [2:0] c1, output int nbusy);
    int got;
    if (who == 0) begin req0 = 1'b1; op0 = op; arg0 = arg; rep0 = rep; end
    else          begin req1 = 1'b1; op1 = op; arg1 = arg; rep1 = rep; end
    got = 0;
    for (int i = 0; i < 6 && got == 0; i++) begin
      tick();
      if ((who == 0) ? gnt0 : gnt1) got = 1;
    end
    chk("cmd_gnt", got, 1);
    req0 = 1'b0; req1 = 1'b0;
    c1 = state;
    nbusy = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      nbusy++;
      tick();
    end
    chk("cmd_done_owner", {done0, done1}, (who == 0) ? 2 : 1);
    chk("cmd_steps", nbusy, op[1] ? int'(rep) + 1 : 1);
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_state", state, 3'b000);
    chk("rst_din", d_in, 8'h00);
    chk("rst_outs", {gnt0, gnt1, done0, done1, busy}, 5'b00000);
    rst = 1'b0;
    tick();

    // 1: LOAD 0x10 from req0
    req0 = 1'b1; op0 = 2'b01; arg0 = 8'h10;
    tick();
    chk("t1_gnt", {gnt0, gnt1, busy}, 3'b101);
    chk("t1_state", state, 3'b001);
    chk("t1_din", d_in, 8'h10);
    req0 = 1'b0; arg0 = 8'h77;
    tick();
    chk("t1_done", {gnt0, done0, busy}, 3'b010);
    chk("t1_count", count_m, 8'h10);

    // 2: INC rep=2, codes 010 011 010
    req0 = 1'b1; op0 = 2'b10; rep0 = 4'h2;
    tick();
    chk("t2_c1", {gnt0, busy, state}, 5'b11010);
    req0 = 1'b0; rep0 = 4'hF;
    tick();
    chk("t2_c2", {gnt0, busy, state}, 5'b01011);
    tick();
    chk("t2_c3", {busy, done0, state}, 5'b10010);
    tick();
    chk("t2_c4", {busy, done0, state}, 5'b01010);
    chk("t2_count", count_m, 8'h13);

    // 3: wrap up then down
    do_cmd(0, 2'b01, 8'hFF, 4'h0, code, nb);
    do_cmd(0, 2'b10, 8'h00, 4'h0, code, nb);
    chk("t3_inc_code", code, 3'b011);
    chk("t3_wrap_up", count_m, 8'h00);
    do_cmd(0, 2'b11, 8'h00, 4'h0, code, nb);
    chk("t3_dec_code", code, 3'b100);
    chk("t3_wrap_down", count_m, 8'hFF);

    // 4: contention, pointer restarted by reset so req0 is favoured
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; op0 = 2'b01; arg0 = 8'h31;
    req1 = 1'b1; op1 = 2'b01; arg1 = 8'h42;
    tick();
    chk("t4_g1", {gnt0, gnt1, d_in}, {2'b10, 8'h31});
    tick();
    chk("t4_d1", {gnt0, gnt1, done0, done1}, 4'b0010);
    tick();
    chk("t4_g2", {gnt0, gnt1, d_in}, {2'b01, 8'h42});
    tick();
    chk("t4_d2", {gnt0, gnt1, done0, done1}, 4'b0001);
    tick();
    chk("t4_g3", {gnt0, gnt1, d_in}, {2'b10, 8'h31});
    req0 = 1'b0;
    tick();
    chk("t4_d3", {gnt0, gnt1, done0, done1}, 4'b0010);
    tick();
    chk("t4_g4", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0;
    tick();
    chk("t4_d4", {done0, done1}, 2'b01);
    do_cmd(1, 2'b01, 8'h55, 4'h0, code, nb);
    chk("t4_lone_count", count_m, 8'h55);

    // 5: reset in the middle of a 16-step INC
    req0 = 1'b1; op0 = 2'b10; rep0 = 4'hF;
    tick();
    chk("t5_gnt", gnt0, 1'b1);
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_step5", {busy, state}, 4'b1010);
    rst = 1'b1;
    #1;
    chk("t5_async", {state, busy, done0, gnt0}, 6'b000000);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done0 || done1 || busy) seen++;
    end
    chk("t5_no_done", seen, 0);
    do_cmd(0, 2'b01, 8'h22, 4'h0, code, nb);
    chk("t5_load", {d_in, count_m}, {8'h22, 8'h22});

    // 6: CLR then single INC
    do_cmd(0, 2'b01, 8'h5A, 4'h0, code, nb);
    chk("t6_pre", count_m, 8'h5A);
    do_cmd(1, 2'b00, 8'h00, 4'h0, code, nb);
    chk("t6_clr_code", code, 3'b000);
    chk("t6_clr_count", count_m, 8'h00);
    do_cmd(0, 2'b10, 8'h00, 4'h0, code, nb);
    chk("t6_inc_count", count_m, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
